// File: rtl/ifetch_pkg.sv
// Shared widths, PC step and the default reset vector for the instruction
// prefetch queue and its FIFO.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a flush that wins over
// push and pop. The head entry is read combinationally from the read pointer.
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !flush;
    assign w_pop  = pop && !flush;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential word
// fetches, buffers {pc, instr} pairs for decode and flushes on redirect.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR,
    localparam int               CW       = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               keep,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CW-1:0]      level,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata
);

    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [ADDR_W-1:0] r_fpc;
    logic [CW-1:0]     w_count;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_wentry;
    fetch_entry_t      w_head;

    // Requesting is gated on the start-of-cycle count, so a push never lands
    // in a full FIFO; redirect withdraws the request so its ack is dropped.
    assign mem_req  = !rst && (w_count < FULL_LVL) && !redirect;
    assign mem_addr = r_fpc;
    assign w_push   = mem_req && mem_ack;
    assign w_pop    = out_valid && !keep;

    assign w_wentry.pc    = r_fpc;
    assign w_wentry.instr = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc <= RESET_PC;
        end else if (redirect) begin
            r_fpc <= redirect_pc;
        end else if (w_push) begin
            r_fpc <= r_fpc + ADDR_W'(PC_STEP);
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .wdata (w_wentry),
        .rdata (w_head),
        .count (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
    assign level     = w_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, fill/drain, full drain with
// fetch, redirect flush, delayed acks and mid-stream reset.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        keep;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  level;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hA5A5_5A5A;
    endfunction

    assign mem_rdata = model(mem_addr);

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .keep        (keep),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .level       (level),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the bench 1 time unit into cycle 0, the first cycle out of reset.
    task automatic do_reset(input logic k, input logic a);
        tick();
        rst      = 1'b1;
        redirect = 1'b0;
        keep     = k;
        mem_ack  = a;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sample();
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (level !== 3'd0) begin n_miss++; $display("FAIL reset_level got %0d want 0", level); end
        n_vec++; if (mem_req !== 1'b0) begin n_miss++; $display("FAIL reset_req got %b want 0", mem_req); end
        tick();
        rst = 1'b0;
        sample();
        n_vec++; if (mem_req !== 1'b1) begin n_miss++; $display("FAIL reset_req_rise got %b want 1", mem_req); end
        n_vec++; if (mem_addr !== 32'h0) begin n_miss++; $display("FAIL reset_addr got %h want 00000000", mem_addr); end
        $display("reset: req=%b addr=%h level=%0d", mem_req, mem_addr, level);
    endtask

    task automatic test_stream();
        do_reset(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            sample();
            $display("stream k=%0d addr=%h valid=%b pc=%h level=%0d", k, mem_addr, out_valid, out_pc, level);
            n_vec++; if (mem_addr !== 32'(4 * k)) begin n_miss++; $display("FAIL stream_addr k=%0d got %h want %h", k, mem_addr, 32'(4 * k)); end
            n_vec++; if (level !== ((k == 0) ? 3'd0 : 3'd1)) begin n_miss++; $display("FAIL stream_level k=%0d got %0d", k, level); end
            if (k > 0) begin
                n_vec++; if (out_pc !== 32'(4 * (k - 1))) begin n_miss++; $display("FAIL stream_pc k=%0d got %h want %h", k, out_pc, 32'(4 * (k - 1))); end
                n_vec++; if (out_instr !== model(32'(4 * (k - 1)))) begin n_miss++; $display("FAIL stream_instr k=%0d got %h want %h", k, out_instr, model(32'(4 * (k - 1)))); end
            end
            tick();
        end
    endtask

    task automatic test_fill_keep();
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sample();
            n_vec++; if (level !== 3'(k)) begin n_miss++; $display("FAIL fill_level k=%0d got %0d want %0d", k, level, k); end
            n_vec++; if (mem_addr !== 32'(4 * k)) begin n_miss++; $display("FAIL fill_addr k=%0d got %h want %h", k, mem_addr, 32'(4 * k)); end
            tick();
        end
        sample();
        n_vec++; if (level !== 3'd4) begin n_miss++; $display("FAIL fill_full_level got %0d want 4", level); end
        n_vec++; if (mem_req !== 1'b0) begin n_miss++; $display("FAIL fill_full_req got %b want 0", mem_req); end
        tick();
        keep    = 1'b0;
        mem_ack = 1'b0;
        for (int j = 0; j < 5; j++) begin
            sample();
            $display("drain j=%0d level=%0d pc=%h req=%b addr=%h", j, level, out_pc, mem_req, mem_addr);
            n_vec++; if (level !== 3'(4 - j)) begin n_miss++; $display("FAIL drain_level j=%0d got %0d want %0d", j, level, 4 - j); end
            if (j < 4) begin
                n_vec++; if (out_pc !== 32'(4 * j)) begin n_miss++; $display("FAIL drain_pc j=%0d got %h want %h", j, out_pc, 32'(4 * j)); end
                n_vec++; if (out_instr !== model(32'(4 * j))) begin n_miss++; $display("FAIL drain_instr j=%0d got %h", j, out_instr); end
            end
            n_vec++; if (mem_req !== (j > 0)) begin n_miss++; $display("FAIL drain_req j=%0d got %b", j, mem_req); end
            if (j > 0) begin
                n_vec++; if (mem_addr !== 32'h10) begin n_miss++; $display("FAIL drain_addr j=%0d got %h want 00000010", j, mem_addr); end
            end
            tick();
        end
    endtask

    task automatic test_full_pop_ack();
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        keep = 1'b0;
        for (int j = 0; j < 7; j++) begin
            sample();
            $display("fullpop j=%0d level=%0d pc=%h", j, level, out_pc);
            n_vec++; if (level !== ((j == 0) ? 3'd4 : 3'd3)) begin n_miss++; $display("FAIL fullpop_level j=%0d got %0d", j, level); end
            n_vec++; if (out_pc !== 32'(4 * j)) begin n_miss++; $display("FAIL fullpop_pc j=%0d got %h want %h", j, out_pc, 32'(4 * j)); end
            n_vec++; if (out_instr !== model(32'(4 * j))) begin n_miss++; $display("FAIL fullpop_instr j=%0d got %h", j, out_instr); end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h14;
        sample();
        n_vec++; if (mem_req !== 1'b0) begin n_miss++; $display("FAIL redir0_req got %b want 0", mem_req); end
        tick();
        redirect = 1'b0;
        mem_ack  = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        sample();
        n_vec++; if (level !== 3'd3) begin n_miss++; $display("FAIL redir_pre_level got %0d want 3", level); end
        n_vec++; if (mem_addr !== 32'h20) begin n_miss++; $display("FAIL redir_pre_addr got %h want 00000020", mem_addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_miss++; $display("FAIL redir_req_drop got %b want 0", mem_req); end
        tick();
        redirect = 1'b0;
        keep     = 1'b0;
        sample();
        $display("redirect: level=%0d valid=%b addr=%h", level, out_valid, mem_addr);
        n_vec++; if (level !== 3'd0) begin n_miss++; $display("FAIL redir_level got %0d want 0", level); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL redir_valid got %b want 0", out_valid); end
        n_vec++; if (mem_addr !== 32'h100) begin n_miss++; $display("FAIL redir_addr got %h want 00000100", mem_addr); end
        n_vec++; if (mem_req !== 1'b1) begin n_miss++; $display("FAIL redir_req got %b want 1", mem_req); end
        tick();
        sample();
        n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL redir_r2_valid got %b want 1", out_valid); end
        n_vec++; if (out_pc !== 32'h100) begin n_miss++; $display("FAIL redir_r2_pc got %h want 00000100", out_pc); end
        n_vec++; if (out_instr !== model(32'h100)) begin n_miss++; $display("FAIL redir_r2_instr got %h want %h", out_instr, model(32'h100)); end
        tick();
        sample();
        n_vec++; if (out_pc !== 32'h104) begin n_miss++; $display("FAIL redir_r3_pc got %h want 00000104", out_pc); end
    endtask

    task automatic test_delayed_ack();
        do_reset(1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ack = 1'b1;
            sample();
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_miss++; $display("FAIL wait_hold c=%0d got req=%b addr=%h want 1/00000000", c, mem_req, mem_addr); end
            n_vec++; if (level !== 3'd0) begin n_miss++; $display("FAIL wait_level c=%0d got %0d want 0", c, level); end
            tick();
        end
        mem_ack = 1'b0;
        for (int c = 4; c < 7; c++) begin
            sample();
            $display("wait c=%0d level=%0d addr=%h", c, level, mem_addr);
            n_vec++; if (level !== 3'd1) begin n_miss++; $display("FAIL wait_push c=%0d got %0d want 1", c, level); end
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_miss++; $display("FAIL wait_hold2 c=%0d got req=%b addr=%h want 1/00000004", c, mem_req, mem_addr); end
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        sample();
        n_vec++; if (level !== 3'd2) begin n_miss++; $display("FAIL wait_second got %0d want 2", level); end
        n_vec++; if (mem_addr !== 32'h8) begin n_miss++; $display("FAIL wait_addr8 got %h want 00000008", mem_addr); end
        n_vec++; if (out_pc !== 32'h0) begin n_miss++; $display("FAIL wait_head got %h want 00000000", out_pc); end
    endtask

    task automatic test_rst_mid();
        do_reset(1'b1, 1'b1);
        tick();
        tick();
        mem_ack = 1'b0;
        sample();
        n_vec++; if (level !== 3'd2) begin n_miss++; $display("FAIL rstmid_pre got %0d want 2", level); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        n_vec++; if (level !== 3'd0) begin n_miss++; $display("FAIL rstmid_level got %0d want 0", level); end
        n_vec++; if (mem_req !== 1'b0) begin n_miss++; $display("FAIL rstmid_req got %b want 0", mem_req); end
        tick();
        tick();
        rst     = 1'b0;
        keep    = 1'b0;
        mem_ack = 1'b1;
        sample();
        $display("rstmid: req=%b addr=%h level=%0d", mem_req, mem_addr, level);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_miss++; $display("FAIL rstmid_restart got req=%b addr=%h want 1/00000000", mem_req, mem_addr); end
        tick();
        sample();
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_miss++; $display("FAIL rstmid_head got valid=%b pc=%h want 1/00000000", out_valid, out_pc); end
        n_vec++; if (out_instr !== model(32'h0)) begin n_miss++; $display("FAIL rstmid_instr got %h want %h", out_instr, model(32'h0)); end
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        keep        = 1'b0;
        mem_ack     = 1'b1;
        test_reset();
        test_stream();
        test_fill_keep();
        test_full_pop_ack();
        test_redirect();
        test_delayed_ack();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
